// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types and depth for the fifo stream reader
package fifo_stream_pkg;

   localparam int unsigned BufDepth = 3;

   typedef logic [1:0] buf_ptr_t;
   typedef logic [1:0] buf_occ_t;

   // Pointers wrap modulo BufDepth rather than at the 2-bit limit.
   function automatic buf_ptr_t ptr_next(input buf_ptr_t p);
      return (p == buf_ptr_t'(BufDepth - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
   endfunction

endpackage

// File: rtl/fifo_stream_buf.sv
// rtl/fifo_stream_buf.sv - 3-entry circular output buffer with push, pop and clear
module fifo_stream_buf
   import fifo_stream_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] head_o,
   output buf_occ_t         occ_o
);

   logic [Width-1:0] r_mem [0:BufDepth-1];
   buf_ptr_t         r_wr_ptr;
   buf_ptr_t         r_rd_ptr;
   buf_occ_t         r_occ;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         for (int i = 0; i < BufDepth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (pop_i) begin
            r_rd_ptr <= ptr_next(r_rd_ptr);
         end
         case ({push_i, pop_i})
            2'b10:   r_occ <= r_occ + buf_occ_t'(1);
            2'b01:   r_occ <= r_occ - buf_occ_t'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign head_o = r_mem[r_rd_ptr];
   assign occ_o  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a fifo read port onto a valid/ready stream
// Optional delivered-word counter enabled by FIFO_STREAM_READER_COUNT_EN.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int unsigned EntrySize  = 8,
   parameter int unsigned CountWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 fifo_read_req_o,
   input  logic                 fifo_read_valid_i,
   input  logic [EntrySize-1:0] fifo_data_i,
   output logic                 stream_valid_o,
   input  logic                 stream_ready_i,
   output logic [EntrySize-1:0] stream_data_o,
   input  logic                 flush_i
`ifdef FIFO_STREAM_READER_COUNT_EN
   ,
   output logic [CountWidth-1:0] count_o
`endif
);

   buf_occ_t   w_occ;
   logic [2:0] w_pending;
   logic       w_req;
   logic       w_push;
   logic       w_pop;
   logic       r_inflight;

   // Words already buffered plus the one still on its way from the fifo;
   // requesting only while this is below the depth keeps the buffer from overflowing.
   assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
   assign w_req     = fifo_read_valid_i && !flush_i && (w_pending < 3'(BufDepth));
   assign w_push    = r_inflight && !flush_i;
   assign w_pop     = stream_valid_o && stream_ready_i && !flush_i;

   assign fifo_read_req_o = w_req;
   assign stream_valid_o  = (w_occ != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_req;
      end
   end

   fifo_stream_buf #(
      .Width (EntrySize)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .clear_i (flush_i),
      .data_i  (fifo_data_i),
      .head_o  (stream_data_o),
      .occ_o   (w_occ)
   );

`ifdef FIFO_STREAM_READER_COUNT_EN
   logic [CountWidth-1:0] r_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count <= '0;
      end else if (w_pop) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count_o = r_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader
// Count checks are active when FIFO_STREAM_READER_COUNT_EN is defined.
module tb_fifo_stream_reader;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       fifo_read_req_o;
   logic       fifo_read_valid_i;
   logic [7:0] fifo_data_i = 8'h00;
   logic       stream_valid_o;
   logic       stream_ready_i = 1'b0;
   logic [7:0] stream_data_o;
   logic       flush_i = 1'b0;
`ifdef FIFO_STREAM_READER_COUNT_EN
   logic [15:0] count_o;
   logic [15:0] count_before;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] fmem [0:63];
   int         wr_idx = 0;
   int         rd_idx = 0;

   logic [7:0] got     [0:63];
   int         got_cyc [0:63];
   int         got_n = 0;
   int         cyc   = 0;

   always #5 clk_i = ~clk_i;

   fifo_stream_reader #(
      .EntrySize  (8),
      .CountWidth (16)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .fifo_read_req_o   (fifo_read_req_o),
      .fifo_read_valid_i (fifo_read_valid_i),
      .fifo_data_i       (fifo_data_i),
      .stream_valid_o    (stream_valid_o),
      .stream_ready_i    (stream_ready_i),
      .stream_data_o     (stream_data_o),
      .flush_i           (flush_i)
`ifdef FIFO_STREAM_READER_COUNT_EN
      ,
      .count_o           (count_o)
`endif
   );

   // Behavioural fifo: a pop accepted at an edge presents its word after that edge.
   assign fifo_read_valid_i = (rd_idx != wr_idx);

   always @(posedge clk_i) begin
      if (fifo_read_req_o && fifo_read_valid_i) begin
         fifo_data_i <= fmem[rd_idx];
         rd_idx      <= rd_idx + 1;
      end
   end

   // Stream monitor samples mid-low-phase, after the bench has settled its inputs.
   always @(negedge clk_i) begin
      #3;
      cyc = cyc + 1;
      if (stream_valid_o && stream_ready_i && !flush_i) begin
         got[got_n]     = stream_data_o;
         got_cyc[got_n] = cyc;
         got_n          = got_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         fmem[wr_idx] = first + 8'(i);
         wr_idx       = wr_idx + 1;
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      #1;
   endtask

   int base;
   int rd_start;

   initial begin
      // Reset behaviour
      step();
      check("rst_req", 32'(fifo_read_req_o), 32'd0);
      check("rst_valid", 32'(stream_valid_o), 32'd0);
      check("rst_data", 32'(stream_data_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      stream_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_req", 32'(fifo_read_req_o), 32'd0);
         check("idle_valid", 32'(stream_valid_o), 32'd0);
         check("idle_data", 32'(stream_data_o), 32'd0);
      end

      // Single word 0xAB: req for one cycle, output two cycles later for one cycle
      base = got_n;
      @(negedge clk_i);
      load(8'hAB, 1);
      #1;
      check("one_req0", 32'(fifo_read_req_o), 32'd1);
      check("one_valid0", 32'(stream_valid_o), 32'd0);
      step();
      check("one_req1", 32'(fifo_read_req_o), 32'd0);
      check("one_valid1", 32'(stream_valid_o), 32'd0);
      step();
      check("one_valid2", 32'(stream_valid_o), 32'd1);
      check("one_data2", 32'(stream_data_o), 32'hAB);
      step();
      check("one_valid3", 32'(stream_valid_o), 32'd0);
      check("one_count", 32'(got_n - base), 32'd1);

      // 0..9 with ready high: no bubbles
      base = got_n;
      @(negedge clk_i);
      load(8'd0, 10);
      repeat (16) step();
      check("burst_n", 32'(got_n - base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check("burst_data", 32'(got[base + i]), 32'(i));
         check("burst_cyc", 32'(got_cyc[base + i] - got_cyc[base]), 32'(i));
      end
`ifdef FIFO_STREAM_READER_COUNT_EN
      check("burst_cnt", 32'(count_o), 32'd11);
`endif

      // 0..9 with ready low: exactly three pops, head held
      base = got_n;
      @(negedge clk_i);
      stream_ready_i = 1'b0;
      rd_start = rd_idx;
      load(8'd0, 10);
      repeat (8) step();
      check("stall_pops", 32'(rd_idx - rd_start), 32'd3);
      check("stall_req", 32'(fifo_read_req_o), 32'd0);
      check("stall_valid", 32'(stream_valid_o), 32'd1);
      check("stall_data", 32'(stream_data_o), 32'd0);
      @(negedge clk_i);
      stream_ready_i = 1'b1;
      repeat (16) step();
      check("stall_n", 32'(got_n - base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         check("stall_order", 32'(got[base + i]), 32'(i));
      end

      // Flush with occ=2 and a pop in flight
      @(negedge clk_i);
      stream_ready_i = 1'b0;
      rd_start = rd_idx;
      load(8'h20, 10);
      repeat (3) step();
      check("fl_pops", 32'(rd_idx - rd_start), 32'd3);
      check("fl_pre_valid", 32'(stream_valid_o), 32'd1);
      check("fl_pre_data", 32'(stream_data_o), 32'h20);
`ifdef FIFO_STREAM_READER_COUNT_EN
      count_before = count_o;
`endif
      @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      check("fl_req", 32'(fifo_read_req_o), 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("fl_valid", 32'(stream_valid_o), 32'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
      check("fl_cnt", 32'(count_o), 32'(count_before));
      check("fl_cnt_abs", 32'(count_o), 32'd21);
`endif
      base = got_n;
      stream_ready_i = 1'b1;
      repeat (14) step();
      check("fl_n", 32'(got_n - base), 32'd7);
      for (int i = 0; i < 7; i++) begin
         check("fl_data", 32'(got[base + i]), 32'h23 + 32'(i));
      end
`ifdef FIFO_STREAM_READER_COUNT_EN
      check("end_cnt", 32'(count_o), 32'd28);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
